// File: rtl/key_typematic_array.sv
// N-channel pushbutton front end: 2-flop synchronizer, debouncer, press/release
// edges and typematic auto-repeat with a slow phase that accelerates to a fast phase.
//
// state   | meaning
// ST_IDLE | not repeating (key up, repeat disabled, or waiting for a press)
// ST_WAIT | press seen, timing the initial HOLD delay before the first repeat
// ST_SLOW | repeating every REPEAT cycles, counting repeats towards ACCEL_AFTER
// ST_FAST | repeating every FAST_REPEAT cycles until release
module key_typematic_array #(
    parameter int N           = 4,
    parameter int DEBOUNCE    = 65536,
    parameter int HOLD        = 25000000,
    parameter int REPEAT      = 5000000,
    parameter int FAST_REPEAT = 1000000,
    parameter int ACCEL_AFTER = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] key_n,
    input  logic [N-1:0] rpt_en,
    output logic [N-1:0] level,
    output logic [N-1:0] press,
    output logic [N-1:0] rel,
    output logic [N-1:0] rpt,
    output logic [N-1:0] pulse,
    output logic         any_pulse
);
    localparam int MAX_DH = (DEBOUNCE > HOLD) ? DEBOUNCE : HOLD;
    localparam int MAX_RF = (REPEAT > FAST_REPEAT) ? REPEAT : FAST_REPEAT;
    localparam int MAX_T  = (MAX_DH > MAX_RF) ? MAX_DH : MAX_RF;
    localparam int CW     = $clog2(MAX_T);
    localparam int RW_RAW = $clog2(ACCEL_AFTER + 1);
    localparam int RW     = (RW_RAW < 1) ? 1 : RW_RAW;

    // Repeat timers are down-counters: loaded with (period - 1) and firing at zero.
    // HOLD loads one less because the load happens in the press cycle itself.
    localparam logic [CW-1:0] DB_TC   = CW'(DEBOUNCE - 1);
    localparam logic [CW-1:0] HOLD_LD = CW'(HOLD - 2);
    localparam logic [CW-1:0] SLOW_LD = CW'(REPEAT - 1);
    localparam logic [CW-1:0] FAST_LD = CW'(FAST_REPEAT - 1);
    localparam logic [RW-1:0] ACC_MAX = RW'(ACCEL_AFTER);
    localparam bit            ACC_ON  = (ACCEL_AFTER != 0);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_SLOW = 2'd2;
    localparam logic [1:0] ST_FAST = 2'd3;

    for (genvar i = 0; i < N; i++) begin : g_ch
        logic          s0, s1, lvl, lvl_d, prs, rls, rp, en_d;
        logic [CW-1:0] db_cnt, tm_cnt;
        logic [RW-1:0] rcnt, rcnt_inc;
        logic [1:0]    st;
        logic          go_fast;

        assign rcnt_inc = (rcnt == ACC_MAX) ? rcnt : rcnt + 1'b1;
        assign go_fast  = ACC_ON && (rcnt_inc == ACC_MAX);

        always_ff @(posedge clk) begin
            if (reset) begin
                s0     <= 1'b0;
                s1     <= 1'b0;
                lvl    <= 1'b0;
                lvl_d  <= 1'b0;
                prs    <= 1'b0;
                rls    <= 1'b0;
                en_d   <= 1'b0;
                db_cnt <= '0;
            end else begin
                s0 <= ~key_n[i];
                s1 <= s0;
                if (s1 == lvl) begin
                    db_cnt <= '0;
                end else if (db_cnt == DB_TC) begin
                    lvl    <= ~lvl;
                    db_cnt <= '0;
                end else begin
                    db_cnt <= db_cnt + 1'b1;
                end
                lvl_d <= lvl;
                prs   <= lvl & ~lvl_d;
                rls   <= ~lvl & lvl_d;
                en_d  <= rpt_en[i];
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                st     <= ST_IDLE;
                tm_cnt <= '0;
                rcnt   <= '0;
                rp     <= 1'b0;
            end else begin
                rp <= 1'b0;
                if (!lvl || !rpt_en[i]) begin
                    st     <= ST_IDLE;
                    tm_cnt <= '0;
                    rcnt   <= '0;
                end else if (prs || !en_d) begin
                    // fresh press, or repeat re-enabled while held: full HOLD again
                    st     <= ST_WAIT;
                    tm_cnt <= HOLD_LD;
                    rcnt   <= '0;
                end else begin
                    case (st)
                        ST_IDLE: st <= ST_IDLE;
                        ST_WAIT, ST_SLOW: begin
                            if (tm_cnt == '0) begin
                                rp   <= 1'b1;
                                rcnt <= rcnt_inc;
                                if (go_fast) begin
                                    st     <= ST_FAST;
                                    tm_cnt <= FAST_LD;
                                end else begin
                                    st     <= ST_SLOW;
                                    tm_cnt <= SLOW_LD;
                                end
                            end else begin
                                tm_cnt <= tm_cnt - 1'b1;
                            end
                        end
                        ST_FAST: begin
                            if (tm_cnt == '0) begin
                                rp     <= 1'b1;
                                tm_cnt <= FAST_LD;
                            end else begin
                                tm_cnt <= tm_cnt - 1'b1;
                            end
                        end
                        default: st <= ST_IDLE;
                    endcase
                end
            end
        end

        assign level[i] = lvl;
        assign press[i] = prs;
        assign rel[i]   = rls;
        assign rpt[i]   = rp;
    end

    assign pulse     = press | rpt;
    assign any_pulse = |pulse;

endmodule

// File: tb/tb_key_typematic_array.sv
// Bench for key_typematic_array: cycle-by-cycle comparison against a schedule-based
// model, plus hand-computed pulse timings for reset, bounce, tap, hold and rpt_en cases.
module tb_key_typematic_array;
    localparam int N   = 2;
    localparam int DEB = 4;
    localparam int HLD = 20;
    localparam int REP = 8;
    localparam int FST = 3;
    localparam int ACC = 2;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] key_n, rpt_en;
    logic [N-1:0] level, press, rel, rpt, pulse;
    logic         any_pulse;

    key_typematic_array #(
        .N(N), .DEBOUNCE(DEB), .HOLD(HLD), .REPEAT(REP), .FAST_REPEAT(FST), .ACCEL_AFTER(ACC)
    ) dut (
        .clk(clk), .reset(reset), .key_n(key_n), .rpt_en(rpt_en),
        .level(level), .press(press), .rel(rel), .rpt(rpt), .pulse(pulse), .any_pulse(any_pulse)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, req);
        end
    endtask

    // Model: sync delay line, disagreement run length for debounce, and absolute
    // cycle scheduling of repeats (next due cycle plus repeats-so-far).
    bit         model_valid = 0;
    bit         m_s0[N], m_s1[N], m_lvl[N], m_lvlp[N], m_enp[N], m_armed[N];
    int         m_run[N], m_next[N], m_k[N];
    logic [N-1:0] e_level = '0, e_press = '0, e_rel = '0, e_rpt = '0;
    bit         nl, np, nr, nrp;
    int         nrun;

    int rpt0_log[64];
    int log_n = 0;
    int cnt_press0 = 0, cnt_rel0 = 0, cnt_rpt0 = 0, cnt_pulse0 = 0, cnt_lvl0 = 0;

    always @(negedge clk) begin
        if (model_valid) begin
            chk("level", {30'b0, level}, {30'b0, e_level});
            chk("press", {30'b0, press}, {30'b0, e_press});
            chk("rel", {30'b0, rel}, {30'b0, e_rel});
            chk("rpt", {30'b0, rpt}, {30'b0, e_rpt});
            chk("pulse", {30'b0, pulse}, {30'b0, e_press | e_rpt});
            chk("any_pulse", {31'b0, any_pulse}, {31'b0, |(e_press | e_rpt)});
            if (rpt[0] === 1'b1) begin
                if (log_n < 64) rpt0_log[log_n] = cyc;
                log_n++;
                cnt_rpt0++;
            end
            if (press[0] === 1'b1) cnt_press0++;
            if (rel[0] === 1'b1) cnt_rel0++;
            if (pulse[0] === 1'b1) cnt_pulse0++;
            if (level[0] === 1'b1) cnt_lvl0++;
        end
        if (reset) begin
            for (int ch = 0; ch < N; ch++) begin
                m_s0[ch] = 0; m_s1[ch] = 0; m_lvl[ch] = 0; m_lvlp[ch] = 0; m_enp[ch] = 0;
                m_armed[ch] = 0; m_run[ch] = 0; m_next[ch] = 0; m_k[ch] = 0;
            end
            e_level = '0; e_press = '0; e_rel = '0; e_rpt = '0;
            model_valid = 1;
        end else if (model_valid) begin
            for (int ch = 0; ch < N; ch++) begin
                nl = m_lvl[ch];
                nrun = 0;
                if (m_s1[ch] != m_lvl[ch]) begin
                    nrun = m_run[ch] + 1;
                    if (nrun == DEB) begin
                        nl = !m_lvl[ch];
                        nrun = 0;
                    end
                end
                np = m_lvl[ch] && !m_lvlp[ch];
                nr = !m_lvl[ch] && m_lvlp[ch];
                nrp = 0;
                if (!m_lvl[ch] || !rpt_en[ch]) begin
                    m_armed[ch] = 0;
                    m_k[ch] = 0;
                end else if (e_press[ch] || !m_enp[ch]) begin
                    m_armed[ch] = 1;
                    m_next[ch] = cyc + HLD;
                    m_k[ch] = 0;
                end else if (m_armed[ch] && m_next[ch] == cyc + 1) begin
                    nrp = 1;
                    m_k[ch]++;
                    m_next[ch] = cyc + 1 + ((ACC != 0 && m_k[ch] >= ACC) ? FST : REP);
                end
                m_s1[ch] = m_s0[ch];
                m_s0[ch] = !key_n[ch];
                m_lvlp[ch] = m_lvl[ch];
                m_lvl[ch] = nl;
                m_run[ch] = nrun;
                m_enp[ch] = rpt_en[ch];
                e_level[ch] = nl;
                e_press[ch] = np;
                e_rel[ch] = nr;
                e_rpt[ch] = nrp;
            end
        end
        cyc++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int t);
        int guard = 0;
        while (cyc < t && guard < 5000) begin
            step();
            guard++;
        end
        chk("wait_bound", {31'b0, cyc >= t}, 32'd1);
    endtask

    int want[$];

    task automatic check_log(input string name, input int from_n, input int base);
        chk({name, "_count"}, log_n - from_n, want.size());
        for (int j = 0; j < want.size(); j++)
            if (from_n + j < log_n && from_n + j < 64)
                chk(name, rpt0_log[from_n + j], base + want[j]);
    endtask

    int r, c, p, ln, sp, sr, st, su, sl;

    initial begin
        reset = 1'b1; key_n = 2'b00; rpt_en = 2'b11;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_outs", {24'b0, level, press, rel, rpt}, 32'd0);
            chk("rst_any", {31'b0, any_pulse}, 32'd0);
        end
        reset = 1'b0;
        r = cyc;
        wait_until(r + 5);
        chk("rst_lvl_early", {30'b0, level}, 32'd0);
        step();
        chk("rst_lvl_rise", {30'b0, level}, 32'd3);
        chk("rst_press_early", {30'b0, press}, 32'd0);
        step();
        chk("rst_press", {30'b0, press}, 32'd3);
        step();
        chk("rst_press_one", {30'b0, press}, 32'd0);
        wait_until(r + 12);
        key_n = 2'b11;
        wait_until(r + 30);

        // bounce on ch0: 3 low, 2 high, 3 low, then high
        sp = cnt_press0; sr = cnt_rel0; sl = cnt_lvl0;
        key_n[0] = 1'b0; repeat (3) step();
        key_n[0] = 1'b1; repeat (2) step();
        key_n[0] = 1'b0; repeat (3) step();
        key_n[0] = 1'b1; repeat (12) step();
        chk("bounce_lvl", cnt_lvl0 - sl, 32'd0);
        chk("bounce_press", cnt_press0 - sp, 32'd0);
        chk("bounce_rel", cnt_rel0 - sr, 32'd0);

        // tap on ch0
        sp = cnt_press0; sr = cnt_rel0; st = cnt_rpt0; su = cnt_pulse0;
        key_n[0] = 1'b0; repeat (10) step();
        key_n[0] = 1'b1; repeat (20) step();
        chk("tap_press", cnt_press0 - sp, 32'd1);
        chk("tap_rel", cnt_rel0 - sr, 32'd1);
        chk("tap_rpt", cnt_rpt0 - st, 32'd0);
        chk("tap_pulse", cnt_pulse0 - su, 32'd1);

        // hold with acceleration
        c = cyc; p = c + 7; ln = log_n; sr = cnt_rel0;
        key_n[0] = 1'b0;
        wait_until(p);
        chk("hold_press", {30'b0, press}, 32'd1);
        wait_until(p + 32);
        key_n[0] = 1'b1;
        wait_until(p + 60);
        want = '{20, 28, 31, 34, 37};
        check_log("hold_rpt", ln, p);
        chk("hold_rel", cnt_rel0 - sr, 32'd1);

        // rpt_en dropped and restored while held
        c = cyc; p = c + 7; ln = log_n;
        key_n[0] = 1'b0;
        wait_until(p + 10);
        rpt_en[0] = 1'b0;
        wait_until(p + 15);
        rpt_en[0] = 1'b1;
        wait_until(p + 40);
        key_n[0] = 1'b1;
        wait_until(p + 70);
        want = '{35, 43, 46};
        check_log("en_rpt", ln, p);

        // ch1 tap coinciding with ch0 first repeat
        c = cyc; p = c + 7; ln = log_n;
        key_n[0] = 1'b0;
        wait_until(p + 13);
        key_n[1] = 1'b0;
        wait_until(p + 20);
        chk("ind_press", {30'b0, press}, 32'd2);
        chk("ind_rpt", {30'b0, rpt}, 32'd1);
        chk("ind_pulse", {30'b0, pulse}, 32'd3);
        chk("ind_any", {31'b0, any_pulse}, 32'd1);
        wait_until(p + 23);
        key_n[1] = 1'b1;
        wait_until(p + 32);
        key_n[0] = 1'b1;
        wait_until(p + 60);
        want = '{20, 28, 31, 34, 37};
        check_log("ind_rpt0", ln, p);

        // reset mid-repeat abandons the pending repeat
        c = cyc; p = c + 7; ln = log_n;
        key_n[0] = 1'b0;
        wait_until(p + 25);
        reset = 1'b1;
        wait_until(p + 27);
        reset = 1'b0;
        chk("midrst_lvl", {30'b0, level}, 32'd0);
        wait_until(p + 30);
        key_n[0] = 1'b1;
        wait_until(p + 50);
        want = '{20};
        check_log("midrst_rpt", ln, p);

        repeat (5) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/key_typematic_array.md
Name: key_typematic_array

Overview:
- N-channel pushbutton front end: per channel 2-flop synchronizer, debouncer, edge detection and typematic auto-repeat with programmable acceleration.
- Generalises the per-key debounce plus hold/repeat logic of the lab top into one parametrised block with synchronous reset, per-channel repeat enable, release events and a fast-repeat stage.
- Sits between raw active-low KEY pins and application control logic, for example increment/decrement of a displayed start value.

Parameters:
- N, 4, number of key channels (1..16).
- DEBOUNCE, 65536, cycles the synchronized input must differ from the debounced level before the level toggles (≥2).
- HOLD, 25000000, cycles from press pulse to first repeat pulse (≥2).
- REPEAT, 5000000, cycles between repeat pulses in slow phase (≥2).
- FAST_REPEAT, 1000000, cycles between repeat pulses in fast phase (≥2).
- ACCEL_AFTER, 10, slow repeats before switching to FAST_REPEAT; 0 means never accelerate.

Ports:
- clk, input, 1, system clock.
- reset, input, 1, synchronous reset, active-high.
- key_n, input, N, raw asynchronous buttons, active-low.
- rpt_en, input, N, per-channel auto-repeat enable (synchronous).
- level, output, N, debounced pressed level (1 = pressed).
- press, output, N, one-cycle pulse on debounced press.
- rel, output, N, one-cycle pulse on debounced release.
- rpt, output, N, one-cycle auto-repeat pulse.
- pulse, output, N, press | rpt (typematic stream for the application).
- any_pulse, output, 1, OR-reduction of pulse.

Behaviour:
- Reset (synchronous, active-high): synchronizers, debounce counters, hold counters, repeat counts, phase flags, level, press, rel, rpt, pulse and any_pulse all go to 0. Reset applied mid-operation abandons all pending events with no pulse.
- Synchronizer: s0 <= ~key_n, then s1 <= s0.
- Debounce, per channel:
  - If s1 == level, the counter clears to 0.
  - Otherwise the counter increments. When the counter equals DEBOUNCE-1 while s1 still differs, level toggles and the counter clears.
  - A raw change held stable changes level on the (DEBOUNCE+2)th clock edge after first being sampled.
  - Any bounce shorter than DEBOUNCE cycles restarts the count and never toggles level.
- Edge detection: press/rel are registered, asserted in the cycle after level rises/falls, for exactly 1 cycle.
- Typematic FSM, per channel, states IDLE, WAIT_HOLD, SLOW, FAST:
  - IDLE: on press pulse, go to WAIT_HOLD with counter 0.
  - WAIT_HOLD: rpt fires exactly HOLD cycles after the press pulse, then go to SLOW.
  - SLOW: rpt every REPEAT cycles. The repeat count increments, saturating at ACCEL_AFTER. If ACCEL_AFTER≠0 and the count reaches ACCEL_AFTER, go to FAST.
    - The ACCEL_AFTER count includes the first, HOLD-timed repeat. If ACCEL_AFTER is 1, the FSM enters FAST directly after the first repeat.
  - FAST: rpt every FAST_REPEAT cycles.
  - level low in any state: go to IDLE same cycle, clear counter and repeat count, no rpt that cycle.
  - rpt_en low: stay or return to IDLE with counter cleared. press and rel are unaffected.
  - rpt_en rising while held: restart in WAIT_HOLD at counter 0 and apply the full HOLD again.
- Simultaneous events:
  - press and rpt are never asserted together on one channel.
  - rel and rpt are never asserted together.
  - Channels are fully independent; several channels may pulse in the same cycle.
- Widths:
  - Counters are sized $clog2 of the largest threshold.
  - The repeat count is sized $clog2(ACCEL_AFTER+1), minimum 1 bit.
  - No counter may wrap.
- Output timing: pulse and any_pulse are combinational from the registered press/rpt and carry no added latency.

Test Plan (bench params N=2, DEBOUNCE=4, HOLD=20, REPEAT=8, FAST_REPEAT=3, ACCEL_AFTER=2):
- Reset: assert reset 3 cycles with key_n=2'b00 (both pressed) → all outputs 0 during reset. Release reset → level[1:0] rises 6 edges later, then press=2'b11 for one cycle.
- Bounce: key_n[0] low 3 cycles, high 2, low 3, then high → level[0] stays 0, no press/rel.
- Tap: key_n[0] low 10 cycles then high, rpt_en=1 → exactly one press and one rel, rpt never asserted, pulse[0] high exactly 1 cycle.
- Hold with acceleration: key_n[0] held low, rpt_en=1, press at cycle P → rpt[0] at P+20 and P+28, then P+31, P+34, P+37. Release → no further rpt; rel asserted.
- rpt_en toggle: holding after press at P, drop rpt_en at P+10 and raise at P+15 → no rpt until P+15+20=P+35.
- Independence: ch0 held (repeating), ch1 tapped at P+20 → press[1] and rpt[0] coincide and any_pulse=1. ch0 timing is unchanged.
